simple_uart_transmitter: RTL and testbench

UART transmitter (8N1, LSB first, line idles high) with a small input FIFO. It is the transmit-side counterpart of simple_uart_receiver. It lets on-board logic on the 250 MHz sys_clk stream bytes (e.g. status or telemetry) out over a GPIO pin to a host. Bytes enter through a valid/ready handshake, are buffered, and are serialised back-to-back with no idle gap while the FIFO holds data.

---
 rtl/simple_uart_transmitter.sv | 167 ++++++++++++++++
 tb/tb_simple_uart_transmitter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simple_uart_transmitter.sv
// simple_uart_transmitter: 8N1 UART transmitter (LSB first, line idles high) fed by a
// small byte FIFO. Bytes are serialised back-to-back with no idle gap while data is queued.
//
// Ports:
//   i_clk        - system clock (sys_clk), single domain
//   i_rst        - synchronous, active-high reset
//   i_dat        - byte to transmit
//   i_dat_vld    - i_dat valid; accepted on an edge where i_dat_vld && o_dat_rdy
//   o_dat_rdy    - FIFO can accept a byte (!full && !i_rst)
//   o_tx         - serial line out, registered, idle high
//   o_busy       - high while a frame (start, data, stop) is on the line
//   o_fifo_level - bytes buffered, excluding the byte being shifted
module simple_uart_transmitter #(
  parameter int unsigned  CLKS_PER_BIT = 2170,
  parameter int unsigned  FIFO_DEPTH   = 16,
  localparam int unsigned LVL_W        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [7:0]       i_dat,
  input  logic             i_dat_vld,
  output logic             o_dat_rdy,
  output logic             o_tx,
  output logic             o_busy,
  output logic [LVL_W-1:0] o_fifo_level
);

  localparam int unsigned      PTR_W    = $clog2(FIFO_DEPTH);
  localparam int unsigned      CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             push, pop, fifo_empty, bit_end;

  assign fifo_empty = (level_q == '0);
  assign o_dat_rdy  = (level_q != LVL_FULL) && !i_rst;
  assign push       = i_dat_vld && o_dat_rdy;
  assign bit_end    = (baud_cnt_q == CNT_LAST);

  assign o_tx         = tx_q;
  assign o_busy       = busy_q;
  assign o_fifo_level = level_q;

  // FIFO storage needs no reset; level and pointers define what is valid.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= i_dat;
    end
  end

  // Pointers wrap naturally since FIFO_DEPTH is a power of two; the explicit level
  // disambiguates full from empty.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Frame FSM. tx_d is the line value for the cycle after the edge, so o_tx is a flop.
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q + CNT_W'(1);
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    pop        = 1'b0;

    unique case (state_q)
      StIdle: begin
        baud_cnt_d = '0;
        tx_d       = 1'b1;
        busy_d     = 1'b0;
        if (!fifo_empty) begin
          pop       = 1'b1;
          shift_d   = mem_q[rd_ptr_q];
          bit_idx_d = '0;
          state_d   = StStart;
          tx_d      = 1'b0;
          busy_d    = 1'b1;
        end
      end
      StStart: begin
        if (bit_end) begin
          baud_cnt_d = '0;
          state_d    = StData;
          tx_d       = shift_q[0];
        end
      end
      StData: begin
        if (bit_end) begin
          baud_cnt_d = '0;
          shift_d    = {1'b0, shift_q[7:1]};
          bit_idx_d  = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = StStop;
            tx_d    = 1'b1;
          end else begin
            // Next bit is what lands in shift[0] after this shift.
            tx_d = shift_q[1];
          end
        end
      end
      StStop: begin
        if (bit_end) begin
          baud_cnt_d = '0;
          if (!fifo_empty) begin
            // Chain straight into the next start bit: no idle cycle between frames.
            pop       = 1'b1;
            shift_d   = mem_q[rd_ptr_q];
            bit_idx_d = '0;
            state_d   = StStart;
            tx_d      = 1'b0;
          end else begin
            state_d = StIdle;
            busy_d  = 1'b0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      state_q    <= StIdle;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
    end
  end

endmodule

// File: tb/tb_simple_uart_transmitter.sv
// Testbench for simple_uart_transmitter (CLKS_PER_BIT=4, FIFO_DEPTH=4).
// Accepted bytes go into an expected queue; a UART receiver model decodes o_tx and
// compares each decoded byte against the head of that queue.
module tb_simple_uart_transmitter;

  localparam int unsigned CPB   = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [7:0]       dat = 8'h00;
  logic             vld = 1'b0;
  logic             rdy;
  logic             tx;
  logic             busy;
  logic [LVL_W-1:0] level;

  simple_uart_transmitter #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_dat       (dat),
    .i_dat_vld   (vld),
    .o_dat_rdy   (rdy),
    .o_tx        (tx),
    .o_busy      (busy),
    .o_fifo_level(level)
  );

  always #2 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] exp_q[$];
  int         start_cyc[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Receiver model: samples mid-bit on the falling clock edge; aborts on reset.
  bit         rx_active = 1'b0;
  int         rx_t      = 0;
  int         bit_n     = 0;
  logic [7:0] rx_byte   = 8'h00;

  always @(negedge clk) begin
    if (rst) begin
      rx_active = 1'b0;
    end else begin
      if (!rx_active && tx === 1'b0) begin
        rx_active = 1'b1;
        rx_t      = 0;
        start_cyc.push_back(cyc);
      end
      if (rx_active) begin
        if (rx_t % CPB == CPB / 2) begin
          bit_n = rx_t / CPB;
          if (bit_n == 0) begin
            check("rx_start_bit", 32'(tx), 32'd0);
          end else if (bit_n <= 8) begin
            rx_byte[bit_n-1] = tx;
          end else begin
            check("rx_stop_bit", 32'(tx), 32'd1);
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL rx_extra_frame: got byte %02h, expected no frame", rx_byte);
            end else begin
              checks--;
              check("rx_byte", 32'(rx_byte), 32'(exp_q.pop_front()));
            end
            rx_active = 1'b0;
          end
        end
        rx_t++;
      end
    end
  end

  task automatic push(input logic [7:0] b);
    int n = 0;
    dat = b;
    vld = 1'b1;
    while (!rdy && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 400) begin
      check("push_rdy_timeout", 32'(rdy), 32'd1);
    end else begin
      @(posedge clk);
      exp_q.push_back(b);
      #1;
    end
    vld = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0) && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, "_drain"}, 32'(exp_q.size()), 32'd0);
    check({name, "_idle_tx"}, 32'(tx), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  logic [9:0] frame_exp;
  int         n0;
  int         n_acc;
  bit         acc;

  initial begin
    // Reset: a byte presented during reset must be dropped.
    rst = 1'b1;
    vld = 1'b1;
    dat = 8'hAA;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("rst_tx", 32'(tx), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_level", 32'(level), 32'd0);
      check("rst_rdy", 32'(rdy), 32'd0);
    end
    rst = 1'b0;
    vld = 1'b0;
    #0;
    check("rdy_after_rst", 32'(rdy), 32'd1);
    repeat (10) @(posedge clk);
    #1;
    check("idle_tx", 32'(tx), 32'd1);
    check("idle_level", 32'(level), 32'd0);
    check("idle_no_frame", 32'(start_cyc.size()), 32'd0);

    // Single byte 0x55: frame is start, d0..d7 LSB first, stop.
    frame_exp = 10'b1_01010101_0;
    dat = 8'h55;
    vld = 1'b1;
    @(posedge clk);  // E0
    exp_q.push_back(8'h55);
    #1;
    vld = 1'b0;
    check("single_level_e0", 32'(level), 32'd1);
    check("single_tx_e0", 32'(tx), 32'd1);
    @(posedge clk);  // E0+1
    #1;
    check("single_level_e1", 32'(level), 32'd0);
    for (int i = 0; i < 10 * CPB; i++) begin
      check("single_wave_tx", 32'(tx), 32'(frame_exp[i/CPB]));
      check("single_wave_busy", 32'(busy), 32'd1);
      @(posedge clk);
      #1;
    end
    check("single_end_busy", 32'(busy), 32'd0);
    check("single_end_tx", 32'(tx), 32'd1);
    drain("single");

    // Back-to-back: three consecutive pushes, start edges exactly one frame apart.
    n0 = start_cyc.size();
    push(8'h00);
    push(8'hFF);
    push(8'hA3);
    drain("b2b");
    check("b2b_frames", 32'(start_cyc.size()), 32'(n0 + 3));
    if (start_cyc.size() == n0 + 3) begin
      check("b2b_gap1", 32'(start_cyc[n0+1] - start_cyc[n0]), 32'(10 * CPB));
      check("b2b_gap2", 32'(start_cyc[n0+2] - start_cyc[n0+1]), 32'(10 * CPB));
    end

    // Full FIFO: hold valid with incrementing data from 0x10.
    dat   = 8'h10;
    vld   = 1'b1;
    n_acc = 0;
    for (int c = 0; c < 600 && n_acc < 8; c++) begin
      acc = rdy;
      @(posedge clk);
      if (acc) begin
        exp_q.push_back(dat);
        n_acc++;
      end
      #1;
      if (acc) begin
        check("full_rdy_after_accept", 32'(rdy), (n_acc >= 5) ? 32'd0 : 32'd1);
        if (n_acc >= 5) check("full_level", 32'(level), 32'(DEPTH));
        dat = dat + 8'd1;
      end
    end
    vld = 1'b0;
    check("full_accepted", 32'(n_acc), 32'd8);
    drain("full");

    // Simultaneous push/pop on the edge where STOP ends.
    n0 = start_cyc.size();
    dat = 8'h31;
    vld = 1'b1;
    @(posedge clk);  // E0
    exp_q.push_back(8'h31);
    #1;
    dat = 8'h32;
    @(posedge clk);  // E0+1, first frame starts
    exp_q.push_back(8'h32);
    #1;
    dat = 8'h33;
    @(posedge clk);  // E0+2
    exp_q.push_back(8'h33);
    #1;
    vld = 1'b0;
    repeat (38) @(posedge clk);  // E0+40, last stop cycle
    #1;
    check("pp_level_before", 32'(level), 32'd2);
    check("pp_tx_stop", 32'(tx), 32'd1);
    dat = 8'h34;
    vld = 1'b1;
    @(posedge clk);  // E0+41, STOP ends: pop and push together
    exp_q.push_back(8'h34);
    #1;
    vld = 1'b0;
    check("pp_level_after", 32'(level), 32'd2);
    check("pp_tx_start", 32'(tx), 32'd0);
    check("pp_busy", 32'(busy), 32'd1);
    drain("pp");
    check("pp_frames", 32'(start_cyc.size()), 32'(n0 + 4));
    if (start_cyc.size() == n0 + 4) begin
      for (int k = 1; k < 4; k++) begin
        check("pp_gap", 32'(start_cyc[n0+k] - start_cyc[n0+k-1]), 32'(10 * CPB));
      end
    end

    // Reset during data bit 3 of 0xC6 with three bytes queued.
    dat = 8'hC6;
    vld = 1'b1;
    @(posedge clk);  // E0
    #1;
    dat = 8'h01;
    @(posedge clk);  // E0+1, frame starts
    #1;
    dat = 8'h02;
    @(posedge clk);
    #1;
    dat = 8'h03;
    @(posedge clk);  // E0+3
    #1;
    vld = 1'b0;
    check("mid_level_queued", 32'(level), 32'd3);
    repeat (14) @(posedge clk);  // E0+17, inside data bit 3
    #1;
    check("mid_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk);  // E0+18
    exp_q.delete();
    #1;
    check("mid_rst_tx", 32'(tx), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_level", 32'(level), 32'd0);
    check("mid_rst_rdy", 32'(rdy), 32'd0);
    rst = 1'b0;
    n0 = start_cyc.size();
    repeat (100) @(posedge clk);
    #1;
    check("mid_no_frames", 32'(start_cyc.size()), 32'(n0));
    check("mid_idle_tx", 32'(tx), 32'd1);
    check("mid_idle_busy", 32'(busy), 32'd0);
    push(8'h5A);
    drain("post_rst");
    check("post_rst_frames", 32'(start_cyc.size()), 32'(n0 + 1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
